// File: rtl/bin_to_bcd_converter.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_converter
//   Sequential shift-and-add-3 (double-dabble) binary to packed-BCD converter.
//   One conversion takes BIN_W SHIFT cycles; the result is registered and held
//   until the next conversion completes.
//
// Parameters
//   BIN_W  : binary input width (4..16)
//   DIGITS : number of BCD digits; must satisfy 10^DIGITS > 2^BIN_W-1
//
// Ports
//   clk   : in  - rising-edge clock
//   reset : in  - synchronous, active-high
//   start : in  - conversion request, accepted in IDLE or DONE
//   bin   : in  - value to convert, captured when start is accepted
//   busy  : out - conversion in progress
//   done  : out - one-cycle pulse, bcd/blank hold a new result
//   bcd   : out - packed result, digit 0 (ones) in bits [3:0]
//   blank : out - per-digit leading-zero blank flags
//
// Optional feature
//   BCD_LEADING_BLANK_EN : when defined, blank[i] (i>=1) flags digits that are
//   zero together with every higher digit; otherwise blank is tied to zero.
// ---------------------------------------------------------------------------
module bin_to_bcd_converter #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank
);

    localparam int          CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned ND    = DIGITS;
    localparam int          SW    = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIN_W-1:0]    sr_q, sr_d;
    logic [SW-1:0]       scratch_q, scratch_d;
    logic [SW-1:0]       bcd_q, bcd_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // One double-dabble step on the current scratch/binary pair
    logic [SW-1:0]       adj;
    logic [SW+BIN_W-1:0] step;
    logic [SW-1:0]       scr_shift;
    logic [BIN_W-1:0]    sr_shift;

    always_comb begin
        adj = scratch_q;
        for (int unsigned i = 0; i < ND; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
        step      = {adj, sr_q} << 1;
        scr_shift = step[SW+BIN_W-1:BIN_W];
        sr_shift  = step[BIN_W-1:0];
    end

`ifdef BCD_LEADING_BLANK_EN
    localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

    logic [DIGITS-1:0] blank_q, blank_d;

    // Walk from the top digit down; a digit is blank until a nonzero digit
    // has been seen at or above it. Digit 0 is never blanked.
    function automatic logic [DIGITS-1:0] blank_of(input logic [SW-1:0] v);
        logic seen;
        blank_of = '0;
        seen     = 1'b0;
        for (int unsigned i = ND - 1; i >= 1; i--) begin
            seen        = seen | (v[4*i +: 4] != 4'd0);
            blank_of[i] = ~seen;
        end
    endfunction
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        scratch_d = scratch_q;
        bcd_d     = bcd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef BCD_LEADING_BLANK_EN
        blank_d   = blank_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                busy_d = 1'b0;
                if (start) begin
                    sr_d      = bin;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(BIN_W);
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end else begin
                    state_d   = IDLE;
                end
            end
            SHIFT: begin
                scratch_d = scr_shift;
                sr_d      = sr_shift;
                cnt_d     = cnt_q - CNT_W'(1);
                // Last shift: publish the final scratch straight into the
                // output register so no intermediate value reaches bcd.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    bcd_d   = scr_shift;
`ifdef BCD_LEADING_BLANK_EN
                    blank_d = blank_of(scr_shift);
`endif
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sr_q      <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef BCD_LEADING_BLANK_EN
            blank_q   <= BLANK_RST;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            scratch_q <= scratch_d;
            bcd_q     <= bcd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef BCD_LEADING_BLANK_EN
            blank_q   <= blank_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
`ifdef BCD_LEADING_BLANK_EN
    assign blank = blank_q;
`else
    assign blank = '0;
`endif

endmodule

// File: doc/bin_to_bcd_converter.md
BIN_TO_BCD_CONVERTER -- requirements
Module: bin_to_bcd_converter

Interface
REQ-001 SHALL have parameter BIN_W, default 8, meaning the binary input width in bits (legal range 4..16).
REQ-002 SHALL have parameter DIGITS, default 3, meaning the number of BCD output digits; the integrator SHALL set DIGITS so that 10^DIGITS > 2^BIN_W-1.
REQ-003 SHALL have port clk, input, 1 bit: system clock (100 MHz); all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: conversion request, sampled on clk.
REQ-006 SHALL have port bin, input, BIN_W bits: unsigned value to convert; sampled only when start is accepted.
REQ-007 SHALL have port busy, output, 1 bit: a conversion is in progress.
REQ-008 SHALL have port done, output, 1 bit: single-cycle pulse marking a valid new result.
REQ-009 SHALL have port bcd, output, 4*DIGITS bits: packed result, digit 0 (ones) in bits [3:0]; each nibble feeds one 4-bit seven-segment decoder input.
REQ-010 SHALL have port blank, output, DIGITS bits: per-digit leading-zero blank flag (see Configuration).

Function
REQ-011 SHALL implement a shift-and-add-3 (double-dabble) converter with FSM states IDLE, SHIFT and DONE.
REQ-012 In IDLE or DONE, start=1 SHALL be accepted: bin is captured into the shift register, the BCD scratch register is cleared, the iteration counter is loaded with BIN_W, and the FSM enters SHIFT.
REQ-013 In SHIFT, each cycle SHALL add 3 to every scratch nibble that is >= 5, then shift the {scratch, binary} register left by one bit, and decrement the counter.
REQ-014 SHALL leave SHIFT for DONE after exactly BIN_W SHIFT cycles.
REQ-015 Latency: start accepted at edge T; busy SHALL be 1 for edges T+1 through T+BIN_W; done=1 and bcd updated at edge T+BIN_W+1 (9 cycles for BIN_W=8).
REQ-016 done SHALL be high for exactly one cycle per completed conversion; the FSM SHALL return to IDLE on the next edge unless start is accepted.
REQ-017 start while busy=1 SHALL be ignored: no restart, no queued request, and bin changes SHALL have no effect.
REQ-018 bcd and blank SHALL hold the last completed result, unchanged during a following conversion, until the next done.
REQ-019 Input 0 SHALL produce bcd all zeros; input 2^BIN_W-1 SHALL produce its exact decimal value (255 gives 0x255 for the defaults).
REQ-020 No intermediate scratch value SHALL be visible on bcd.

Reset
REQ-021 While reset=1 at an edge, the FSM SHALL go to IDLE, busy=0, done=0, bcd=0, blank=all ones except digit 0, and the counter and scratch registers SHALL be 0.
REQ-022 reset SHALL take priority over start and SHALL abort a conversion mid-SHIFT with no done pulse.
REQ-023 The first start after reset deasserts SHALL be accepted normally.

Configuration
REQ-024 Macro BCD_LEADING_BLANK_EN: when defined, at done blank[i] SHALL be 1 for i>=1 if digit i and all higher digits are 0; blank[0] SHALL always be 0.
REQ-025 Without BCD_LEADING_BLANK_EN, blank SHALL be constant all zeros and no blanking logic SHALL be synthesized.

Verification
REQ-026 Defaults: reset, then pulse start with bin=8'd173 -> busy high 8 cycles, done pulse 9 cycles after start, bcd=12'h173.
REQ-027 Run bin=0 then bin=255 back to back, with start raised in the done cycle -> bcd=12'h000 then 12'h255; second conversion starts without an idle gap.
REQ-028 Pulse start again and toggle bin mid-conversion -> start ignored, result reflects the originally captured bin, exactly one done pulse.
REQ-029 Assert reset at SHIFT cycle 4 -> no done, bcd=0, busy=0 next cycle; a new start with bin=42 then gives bcd=12'h042.
REQ-030 With BCD_LEADING_BLANK_EN, bin=7 -> blank=3'b110; bin=40 -> 3'b100; bin=200 -> 3'b000. Without the macro, blank=3'b000 in all three cases.
REQ-031 Exhaustive sweep of bin 0..255 against a reference model -> every bcd nibble <= 9 and every result equals the input in decimal.
